// File: rtl/lc3_regfile_pkg.sv
// Shared constants, the destination-register type and the DR-to-write-enable
// decoder for the LC3 register-file write path.
package lc3_regfile_pkg;

  localparam int REG_W   = 16;
  localparam int NUM_GPR = 8;
  localparam int DR_W    = 3;

  typedef logic [DR_W-1:0] dr_t;

  function automatic logic [NUM_GPR-1:0] dr_to_onehot(input dr_t dr);
    logic [NUM_GPR-1:0] oh;
    oh     = '0;
    oh[dr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin starting at rr_ptr, or
// fixed priority (lowest index) when FIXED_PRIO is set.
module rr_picker #(
  parameter int NUM_REQ    = 3,
  parameter int FIXED_PRIO = 0,
  localparam int PTR_W     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   winner
);

  int w_idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_idx  = 0;
    if (FIXED_PRIO != 0) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          valid  = 1'b1;
          winner = PTR_W'(i);
        end
      end
    end else begin
      // Scan offsets downward so the smallest offset from rr_ptr is kept last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_idx = int'(rr_ptr) + k;
        if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
        if (eligible[w_idx]) begin
          valid  = 1'b1;
          winner = PTR_W'(w_idx);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single LC3 register-file write port among NUM_REQ
// writeback requesters and registers the winning write.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int FIXED_PRIO = 0,
  parameter int REG_W      = 16,
  parameter int NUM_GPR    = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [3*NUM_REQ-1:0]     req_dr,
  input  logic [REG_W*NUM_REQ-1:0] req_data,
  input  logic                     stall,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_GPR-1:0]       reg_we,
  output logic [REG_W-1:0]         reg_d,
  output logic                     busy
);

  import lc3_regfile_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] r_ack_p1;
  logic [NUM_GPR-1:0] r_we_p1;
  logic [REG_W-1:0]   r_d_p1;
  logic [PTR_W-1:0]   r_rr_ptr;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_valid;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_ack_oh;
  dr_t                w_dr;
  logic [REG_W-1:0]   w_data;

  // The requester committing this cycle is masked so it cannot win twice
  // before it has had a chance to drop req.
  assign w_elig = req & ~r_ack_p1;
  assign busy   = |w_elig;

  rr_picker #(
    .NUM_REQ    (NUM_REQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_picker (
    .eligible (w_elig),
    .rr_ptr   (r_rr_ptr),
    .valid    (w_valid),
    .winner   (w_win)
  );

  always_comb begin
    w_dr   = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_dr   = req_dr[i*DR_W +: DR_W];
        w_data = req_data[i*REG_W +: REG_W];
      end
    end
  end

  assign w_ack_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Stage p1: registered grant driving the register file for one cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_ack_p1 <= '0;
      r_we_p1  <= '0;
      r_d_p1   <= '0;
      r_rr_ptr <= '0;
    end else if (!stall && w_valid) begin
      r_ack_p1 <= w_ack_oh;
      r_we_p1  <= dr_to_onehot(w_dr);
      r_d_p1   <= w_data;
      r_rr_ptr <= w_ptr_nxt;
    end else begin
      r_ack_p1 <= '0;
      r_we_p1  <= '0;
    end
  end

  assign ack    = r_ack_p1;
  assign reg_we = r_we_p1;
  assign reg_d  = r_d_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance, with a
// behavioural R0..R7 register file fed by reg_we/reg_d.
module tb_regfile_write_arbiter;

  logic        Clk;
  logic        Reset;
  logic [2:0]  req;
  logic [8:0]  req_dr;
  logic [47:0] req_data;
  logic        stall;
  logic [2:0]  ack;
  logic [7:0]  reg_we;
  logic [15:0] reg_d;
  logic        busy;

  logic [2:0]  fp_req;
  logic [8:0]  fp_dr;
  logic [47:0] fp_data;
  logic        fp_stall;
  logic [2:0]  fp_ack;
  logic [7:0]  fp_we;
  logic [15:0] fp_d;
  logic        fp_busy;

  logic [15:0] rf [8] = '{default: 16'h0000};

  int errors = 0;
  int checks = 0;
  int rr_seq [6] = '{2, 0, 1, 2, 0, 1};

  regfile_write_arbiter #(.NUM_REQ(3), .FIXED_PRIO(0), .REG_W(16), .NUM_GPR(8)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_dr(req_dr), .req_data(req_data),
    .stall(stall), .ack(ack), .reg_we(reg_we), .reg_d(reg_d), .busy(busy)
  );

  regfile_write_arbiter #(.NUM_REQ(3), .FIXED_PRIO(1), .REG_W(16), .NUM_GPR(8)) dut_fp (
    .Clk(Clk), .Reset(Reset), .req(fp_req), .req_dr(fp_dr), .req_data(fp_data),
    .stall(fp_stall), .ack(fp_ack), .reg_we(fp_we), .reg_d(fp_d), .busy(fp_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    for (int i = 0; i < 8; i++)
      if (reg_we[i]) rf[i] <= reg_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b0;
    stall    = 1'b0;
    req      = 3'b111;
    req_dr   = {3'd0, 3'd0, 3'd1};
    req_data = {16'h0000, 16'h0000, 16'h0A0A};
    fp_req   = 3'b000;
    fp_dr    = '0;
    fp_data  = '0;
    fp_stall = 1'b0;

    // Reset held with all requesting
    tick();
    tick();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_we", 32'(reg_we), 32'h0);
    check("rst_d", 32'(reg_d), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    Reset = 1'b1;
    tick();
    check("first_ack", 32'(ack), 32'h1);
    check("first_we", 32'(reg_we), 32'h02);
    check("first_d", 32'(reg_d), 32'h0A0A);
    req = 3'b000;
    tick();
    check("first_ack_drop", 32'(ack), 32'h0);
    check("first_r1", 32'(rf[1]), 32'h0A0A);
    check("idle_busy", 32'(busy), 32'h0);

    // Single write from requester 1 to R5
    req_dr   = {3'd0, 3'd5, 3'd0};
    req_data = {16'h0000, 16'hBEEF, 16'h0000};
    req      = 3'b010;
    tick();
    check("single_ack", 32'(ack), 32'h2);
    check("single_we", 32'(reg_we), 32'h20);
    check("single_d", 32'(reg_d), 32'hBEEF);
    req = 3'b000;
    tick();
    check("single_r5", 32'(rf[5]), 32'hBEEF);
    check("single_ack_drop", 32'(ack), 32'h0);

    // Round-robin with all three requesting; pointer starts at 2
    req_dr   = {3'd6, 3'd5, 3'd4};
    req_data = {16'hC002, 16'hC001, 16'hC000};
    req      = 3'b111;
    for (int s = 0; s < 6; s++) begin
      tick();
      check("rr_ack", 32'(ack), 32'(1) << rr_seq[s]);
      check("rr_we", 32'(reg_we), 32'(1) << (4 + rr_seq[s]));
      check("rr_d", 32'(reg_d), 32'hC000 + 32'(rr_seq[s]));
      req = ~(3'b001 << rr_seq[s]);
    end
    req = 3'b000;
    tick();
    check("rr_idle_ack", 32'(ack), 32'h0);
    check("rr_r4", 32'(rf[4]), 32'hC000);
    check("rr_r6", 32'(rf[6]), 32'hC002);

    // Stall for three cycles with requesters 0 and 2 pending
    req_dr   = {3'd7, 3'd0, 3'd0};
    req_data = {16'h4002, 16'h0000, 16'h4000};
    req      = 3'b101;
    stall    = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_ack", 32'(ack), 32'h0);
      check("stall_we", 32'(reg_we), 32'h0);
      check("stall_d_hold", 32'(reg_d), 32'hC001);
      check("stall_busy", 32'(busy), 32'h1);
    end
    stall = 1'b0;
    tick();
    check("unstall_ack", 32'(ack), 32'h4);
    check("unstall_we", 32'(reg_we), 32'h80);
    check("unstall_d", 32'(reg_d), 32'h4002);
    req = 3'b001;
    tick();
    check("unstall2_ack", 32'(ack), 32'h1);
    check("unstall2_we", 32'(reg_we), 32'h01);
    check("unstall2_d", 32'(reg_d), 32'h4000);
    req = 3'b000;
    tick();

    // Move the pointer to 2, then collide on R3
    req_dr   = {3'd0, 3'd1, 3'd0};
    req_data = {16'h0000, 16'h5001, 16'h0000};
    req      = 3'b010;
    tick();
    check("prep_ack", 32'(ack), 32'h2);
    req = 3'b000;
    tick();
    req_dr   = {3'd3, 3'd1, 3'd3};
    req_data = {16'h2222, 16'h5001, 16'h1111};
    req      = 3'b101;
    tick();
    check("coll1_ack", 32'(ack), 32'h4);
    check("coll1_we", 32'(reg_we), 32'h08);
    check("coll1_d", 32'(reg_d), 32'h2222);
    req = 3'b001;
    tick();
    check("coll2_ack", 32'(ack), 32'h1);
    check("coll2_d", 32'(reg_d), 32'h1111);
    check("coll_r3_mid", 32'(rf[3]), 32'h2222);
    req = 3'b000;
    tick();
    check("coll_r3_final", 32'(rf[3]), 32'h1111);
    check("coll_idle_ack", 32'(ack), 32'h0);

    // Fixed priority: req0 and req1 held continuously
    fp_dr   = {3'd0, 3'd1, 3'd0};
    fp_data = {16'h0000, 16'h6001, 16'h6000};
    fp_req  = 3'b011;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("fp_ack", 32'(fp_ack), 32'(1) << (s % 2));
      check("fp_we", 32'(fp_we), 32'(1) << (s % 2));
      check("fp_d", 32'(fp_d), 32'h6000 + 32'(s % 2));
      check("fp_busy", 32'(fp_busy), 32'h1);
    end
    fp_req = 3'b000;
    tick();
    check("fp_idle_ack", 32'(fp_ack), 32'h0);

    // Reset asserted while a write to R2 is in flight
    req_dr   = {3'd2, 3'd0, 3'd0};
    req_data = {16'hDEAD, 16'h0000, 16'h0000};
    req      = 3'b100;
    tick();
    check("pre_rst_we", 32'(reg_we), 32'h04);
    Reset = 1'b0;
    #1;
    check("midrst_we", 32'(reg_we), 32'h0);
    check("midrst_ack", 32'(ack), 32'h0);
    check("midrst_d", 32'(reg_d), 32'h0);
    tick();
    check("midrst_r2", 32'(rf[2]), 32'h0);
    Reset = 1'b1;
    tick();
    check("rearb_ack", 32'(ack), 32'h4);
    check("rearb_we", 32'(reg_we), 32'h04);
    check("rearb_d", 32'(reg_d), 32'hDEAD);
    req = 3'b000;
    tick();
    check("rearb_r2", 32'(rf[2]), 32'hDEAD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
